// File: rtl/cam_pkg.sv
// Camera capture shared definitions.
// Also consumed by the frame transmit controller.
package cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cam_state_t;

  localparam int XLK_HALF   = 3;
  localparam int XLK_W      = $clog2(XLK_HALF + 1);
  localparam int H_BYTES    = 352;
  localparam int KEEP_PHASE = 1;
  localparam int LINE_DECIM = 2;
  localparam int MAX_BYTES  = 12672;
  localparam int ADDR_W     = 15;
  localparam int CNT_W      = 10;

  // A byte is kept when it is the luma phase of a pixel
  // pair on a retained line and lies inside the line.
  function automatic logic keep_byte(
    input logic [CNT_W-1:0] i_byte,
    input logic [CNT_W-1:0] i_line
  );
    return ((int'(i_byte) % 2) == KEEP_PHASE)
        && ((int'(i_line) % LINE_DECIM) == 0)
        && (int'(i_byte) < H_BYTES);
  endfunction

endpackage

// File: rtl/cam_edge_sync.sv
// Two-flop synchroniser for an async camera strobe,
// with a third stage for rise/fall detection.
module cam_edge_sync (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Async,
  output logic o_Level,
  output logic o_Rise,
  output logic o_Fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Shift the async level through three flops.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_Async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_Level = r_s2;
  assign o_Rise  = r_s2 & ~r_s3;
  assign o_Fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/camera_frame_capture.sv
// Drives the camera master clock and writes one
// decimated QCIF luma frame into the frame RAM.
module camera_frame_capture
  import cam_pkg::*;
(
  input  logic              Clk,
  input  logic              i_Rst,
  input  logic              i_Enable,
  input  logic [7:0]        i_D,
  input  logic              i_PLK,
  input  logic              i_VS,
  input  logic              i_HS,
  output logic              o_XLK,
  output logic [7:0]        o_Data,
  output logic [ADDR_W-1:0] o_Addr,
  output logic              o_WE,
  output logic              o_Frame_Done,
  output logic              o_Busy,
  output logic              o_Overflow
);

  localparam logic [XLK_W-1:0] XLK_LAST =
    XLK_W'(XLK_HALF - 1);
  localparam logic [ADDR_W-1:0] ADDR_FULL =
    ADDR_W'(MAX_BYTES);

  logic [XLK_W-1:0]  r_xlk_cnt;
  logic [7:0]        r_d_s1;
  logic [7:0]        r_d_s2;
  cam_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_line;
  logic [CNT_W-1:0]  r_byte;

  logic w_plk_lvl;
  logic w_plk_rise;
  logic w_plk_fall;
  logic w_vs_lvl;
  logic w_vs_rise;
  logic w_vs_fall;
  logic w_hs_lvl;
  logic w_hs_rise;
  logic w_hs_fall;
  logic w_keep;
  logic w_addr_full;
  logic w_unused;

  cam_edge_sync u_plk_sync (
    .i_Clk   (Clk),
    .i_Rst   (i_Rst),
    .i_Async (i_PLK),
    .o_Level (w_plk_lvl),
    .o_Rise  (w_plk_rise),
    .o_Fall  (w_plk_fall)
  );

  cam_edge_sync u_vs_sync (
    .i_Clk   (Clk),
    .i_Rst   (i_Rst),
    .i_Async (i_VS),
    .o_Level (w_vs_lvl),
    .o_Rise  (w_vs_rise),
    .o_Fall  (w_vs_fall)
  );

  cam_edge_sync u_hs_sync (
    .i_Clk   (Clk),
    .i_Rst   (i_Rst),
    .i_Async (i_HS),
    .o_Level (w_hs_lvl),
    .o_Rise  (w_hs_rise),
    .o_Fall  (w_hs_fall)
  );

  assign w_unused =
    w_plk_lvl ^ w_plk_fall ^ w_vs_lvl ^ w_hs_rise;

  assign w_keep      = keep_byte(r_byte, r_line);
  assign w_addr_full = (r_addr == ADDR_FULL);

  // Free-running camera master clock divider.
  always_ff @(posedge Clk) begin
    if (i_Rst) begin
      r_xlk_cnt <= '0;
      o_XLK     <= 1'b0;
    end else if (r_xlk_cnt == XLK_LAST) begin
      r_xlk_cnt <= '0;
      o_XLK     <= ~o_XLK;
    end else begin
      r_xlk_cnt <= r_xlk_cnt + 1'b1;
    end
  end

  // Data follows the same two stages as PLK so the
  // byte lines up with the detected PLK rise.
  always_ff @(posedge Clk) begin
    if (i_Rst) begin
      r_d_s1 <= '0;
      r_d_s2 <= '0;
    end else begin
      r_d_s1 <= i_D;
      r_d_s2 <= r_d_s1;
    end
  end

  // Capture FSM with registered RAM-side outputs.
  always_ff @(posedge Clk) begin
    if (i_Rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_line       <= '0;
      r_byte       <= '0;
      o_Data       <= '0;
      o_Addr       <= '0;
      o_WE         <= 1'b0;
      o_Frame_Done <= 1'b0;
      o_Busy       <= 1'b0;
      o_Overflow   <= 1'b0;
    end else begin
      o_WE         <= 1'b0;
      o_Frame_Done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_Enable) begin
            r_state <= ST_ARM;
            o_Busy  <= 1'b1;
          end
        end
        ST_ARM: begin
          if (!i_Enable) begin
            r_state <= ST_IDLE;
            o_Busy  <= 1'b0;
          end else if (w_vs_fall) begin
            r_state    <= ST_CAPTURE;
            r_addr     <= '0;
            r_line     <= '0;
            r_byte     <= '0;
            o_Overflow <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (!i_Enable) begin
            r_state <= ST_IDLE;
            o_Busy  <= 1'b0;
          end else begin
            if (w_plk_rise && w_hs_lvl) begin
              if (w_keep) begin
                if (w_addr_full) begin
                  o_Overflow <= 1'b1;
                end else begin
                  o_WE   <= 1'b1;
                  o_Data <= r_d_s2;
                  o_Addr <= r_addr;
                  r_addr <= r_addr + 1'b1;
                end
              end
              if (r_byte != '1) begin
                r_byte <= r_byte + 1'b1;
              end
            end
            if (w_hs_fall) begin
              r_line <= r_line + 1'b1;
              r_byte <= '0;
            end
            if (w_vs_rise) begin
              r_state      <= ST_DONE;
              o_Frame_Done <= 1'b1;
              o_Busy       <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_camera_frame_capture.sv
// Bench for camera_frame_capture: camera bus model,
// write scoreboard and directed frame scenarios.
module tb_camera_frame_capture;
  import cam_pkg::*;

  logic              Clk = 1'b0;
  logic              i_Rst = 1'b1;
  logic              i_Enable = 1'b0;
  logic [7:0]        i_D = '0;
  logic              i_PLK = 1'b0;
  logic              i_VS = 1'b0;
  logic              i_HS = 1'b0;
  logic              o_XLK;
  logic [7:0]        o_Data;
  logic [ADDR_W-1:0] o_Addr;
  logic              o_WE;
  logic              o_Frame_Done;
  logic              o_Busy;
  logic              o_Overflow;

  always #4 Clk = ~Clk;

  camera_frame_capture dut (
    .Clk          (Clk),
    .i_Rst        (i_Rst),
    .i_Enable     (i_Enable),
    .i_D          (i_D),
    .i_PLK        (i_PLK),
    .i_VS         (i_VS),
    .i_HS         (i_HS),
    .o_XLK        (o_XLK),
    .o_Data       (o_Data),
    .o_Addr       (o_Addr),
    .o_WE         (o_WE),
    .o_Frame_Done (o_Frame_Done),
    .o_Busy       (o_Busy),
    .o_Overflow   (o_Overflow)
  );

  typedef struct packed {
    logic [14:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t  exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   n_we = 0;
  int   n_done = 0;
  int   exp_addr = 0;
  int   exp_done = 0;
  int   abort_at = 0;
  int   abort_kind = 0;
  int   we_base = 0;
  bit   cap = 1'b0;
  bit   exp_ovf = 1'b0;
  logic [14:0] last_a = '0;
  logic [7:0]  last_d = '0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Scoreboard: every write must match the oldest
  // expected write; stray writes are failures.
  always @(posedge Clk) begin
    #1;
    if (o_WE === 1'b1) begin
      n_we++;
      last_a = o_Addr;
      last_d = o_Data;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stray_we: addr=%0d data=%0d, none expected",
                 o_Addr, o_Data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(o_Addr), 32'(e.a));
        check("wr_data", 32'(o_Data), 32'(e.d));
      end
    end
    if (o_Frame_Done === 1'b1) n_done++;
  end

  // Frame semantics: odd bytes of even lines within
  // 352 bytes land at consecutive addresses < 12672.
  task automatic model_byte(input int ln, input int b);
    wr_t e;
    if (cap && (ln % 2 == 0) && (b % 2 == 1) && (b < 352)) begin
      if (exp_addr < 12672) begin
        e.a = 15'(exp_addr);
        e.d = 8'(ln ^ b);
        exp_q.push_back(e);
        exp_addr++;
      end else begin
        exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic do_abort();
    exp_q.delete();
    cap = 1'b0;
    abort_at = 0;
    if (abort_kind == 1) begin
      i_Enable = 1'b0;
    end else begin
      exp_ovf = 1'b0;
      i_Rst = 1'b1;
      @(posedge Clk);
      #1;
      check("rst_mid_we", 32'(o_WE), 0);
      check("rst_mid_busy", 32'(o_Busy), 0);
      check("rst_mid_ovf", 32'(o_Overflow), 0);
      check("rst_mid_addr", 32'(o_Addr), 0);
      check("rst_mid_data", 32'(o_Data), 0);
      @(negedge Clk);
      i_Rst = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    if (abort_at > 0 && (n_we - we_base) >= abort_at)
      do_abort();
  endtask

  task automatic send_line(input int ln, input int nb);
    for (int b = 0; b < nb; b++) begin
      tick();
      i_HS  = 1'b1;
      i_PLK = 1'b0;
      i_D   = 8'(ln ^ b);
      model_byte(ln, b);
      tick();
      i_PLK = 1'b1;
    end
    tick();
    i_PLK = 1'b0;
    i_HS  = 1'b0;
    repeat (3) tick();
  endtask

  task automatic frame_start();
    tick();
    i_VS  = 1'b1;
    i_HS  = 1'b0;
    i_PLK = 1'b0;
    if (cap) begin
      exp_addr = 0;
      exp_ovf  = 1'b0;
    end
    repeat (4) tick();
    i_VS = 1'b0;
    repeat (4) tick();
  endtask

  task automatic frame_end();
    tick();
    i_VS = 1'b1;
    if (cap) exp_done++;
    repeat (8) tick();
  endtask

  task automatic lines(input int n, input int even_nb);
    for (int ln = 0; ln < n; ln++)
      send_line(ln, (ln % 2 == 0) ? even_nb : 6);
  endtask

  initial begin
    logic [9:0] xs;
    int per;
    logic prev;

    // Reset and XLK
    repeat (4) @(posedge Clk);
    #1;
    check("rst_xlk", 32'(o_XLK), 0);
    check("rst_data", 32'(o_Data), 0);
    check("rst_addr", 32'(o_Addr), 0);
    check("rst_we", 32'(o_WE), 0);
    check("rst_done", 32'(o_Frame_Done), 0);
    check("rst_busy", 32'(o_Busy), 0);
    check("rst_ovf", 32'(o_Overflow), 0);
    @(negedge Clk);
    i_Rst = 1'b0;
    xs = '0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge Clk);
      #1;
      xs[k] = o_XLK;
    end
    check("xlk_c2", 32'(xs[2]), 0);
    check("xlk_c3", 32'(xs[3]), 1);
    check("xlk_c5", 32'(xs[5]), 1);
    check("xlk_c6", 32'(xs[6]), 0);
    check("xlk_c9", 32'(xs[9]), 1);
    per = -1;
    prev = o_XLK;
    for (int k = 1; k <= 20; k++) begin
      @(posedge Clk);
      #1;
      if (o_XLK && !prev && per < 0) per = k;
      prev = o_XLK;
    end
    check("xlk_period", 32'(per), 6);
    check("idle_busy", 32'(o_Busy), 0);

    // Disabled through a whole frame
    cap = 1'b0;
    frame_start();
    lines(6, 352);
    frame_end();
    check("gate_off_we", 32'(n_we), 0);
    check("gate_off_done", 32'(n_done), 0);

    // Enabled after the frame start: no writes
    frame_start();
    i_Enable = 1'b1;
    lines(4, 352);
    frame_end();
    check("gate_mid_we", 32'(n_we), 0);
    check("gate_mid_done", 32'(n_done), 0);
    check("gate_mid_busy", 32'(o_Busy), 1);

    // Next frame captures normally
    we_base = n_we;
    cap = 1'b1;
    frame_start();
    lines(4, 352);
    frame_end();
    check("f4_we", 32'(n_we - we_base), 352);
    check("f4_last_a", 32'(last_a), 351);
    check("f4_last_d", 32'(last_d), 32'h5D);
    check("f4_done", 32'(n_done), 32'(exp_done));
    check("f4_done_lit", 32'(n_done), 1);
    check("f4_q", 32'(exp_q.size()), 0);

    // Short frame of 10 lines
    we_base = n_we;
    cap = 1'b1;
    frame_start();
    lines(10, 352);
    frame_end();
    check("short_we", 32'(n_we - we_base), 880);
    check("short_last_a", 32'(last_a), 879);
    check("short_last_d", 32'(last_d), 32'h57);
    check("short_done", 32'(n_done), 32'(exp_done));
    check("short_ovf", 32'(o_Overflow), 32'(exp_ovf));
    check("short_ovf_lit", 32'(o_Overflow), 0);
    check("short_q", 32'(exp_q.size()), 0);

    // Abort by dropping enable after 500 writes
    we_base = n_we;
    abort_kind = 1;
    abort_at = 500;
    cap = 1'b1;
    frame_start();
    lines(6, 352);
    frame_end();
    check("abort_we", 32'(n_we - we_base), 500);
    check("abort_done", 32'(n_done), 32'(exp_done));
    check("abort_busy", 32'(o_Busy), 0);
    i_Enable = 1'b1;
    repeat (3) tick();

    // Long frame: full 144 lines, then overflow
    we_base = n_we;
    cap = 1'b1;
    frame_start();
    lines(144, 352);
    check("full_we", 32'(n_we - we_base), 12672);
    check("full_last_a", 32'(last_a), 12671);
    check("full_last_d", 32'(last_d), 32'hD1);
    check("full_ovf", 32'(o_Overflow), 32'(exp_ovf));
    check("full_ovf_lit", 32'(o_Overflow), 0);
    check("full_q", 32'(exp_q.size()), 0);
    send_line(144, 8);
    send_line(145, 6);
    check("ovf_set", 32'(o_Overflow), 32'(exp_ovf));
    check("ovf_set_lit", 32'(o_Overflow), 1);
    frame_end();
    check("ovf_we", 32'(n_we - we_base), 12672);
    check("ovf_last_a", 32'(last_a), 12671);
    check("ovf_done", 32'(n_done), 32'(exp_done));
    check("ovf_sticky", 32'(o_Overflow), 1);

    // Reset in the middle of a capture
    we_base = n_we;
    abort_kind = 2;
    abort_at = 20;
    cap = 1'b1;
    frame_start();
    lines(3, 352);
    frame_end();
    check("rstab_we", 32'(n_we - we_base), 20);
    check("rstab_done", 32'(n_done), 32'(exp_done));
    check("rstab_ovf", 32'(o_Overflow), 0);
    check("rstab_rearm", 32'(o_Busy), 1);
    check("rstab_q", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
